// File: rtl/robot_pkg.sv
// robot_pkg: definitions shared by the motor command path.
//   motor_cmd_t / CMD_*  : one-hot motor command encoding (all-zero = STOP)
//   grant_t              : which source produced the current request
//   arb_state_t          : motor_cmd_arbiter state machine encoding
//   cmd_is_valid()       : true for STOP and the five one-hot commands
package robot_pkg;

  typedef logic [4:0] motor_cmd_t;

  localparam motor_cmd_t CMD_STOP  = 5'b00000;
  localparam motor_cmd_t CMD_FWD   = 5'b00001;
  localparam motor_cmd_t CMD_REV   = 5'b00010;
  localparam motor_cmd_t CMD_LEFT  = 5'b00100;
  localparam motor_cmd_t CMD_RIGHT = 5'b01000;
  localparam motor_cmd_t CMD_SPIN  = 5'b10000;

  typedef enum logic [1:0] {
    GRANT_FSM    = 2'd0,
    GRANT_IR     = 2'd1,
    GRANT_SAFETY = 2'd2
  } grant_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_DRIVE    = 2'd1,
    ARB_DEADTIME = 2'd2
  } arb_state_t;

  // Anything that is not STOP or a single known direction bit is illegal.
  function automatic logic cmd_is_valid(input motor_cmd_t cmd);
    logic ok;
    case (cmd)
      CMD_STOP, CMD_FWD, CMD_REV, CMD_LEFT, CMD_RIGHT, CMD_SPIN: ok = 1'b1;
      default:                                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: saturating counter with a synchronous load.
//   COUNT_UP = 0 : counts down and sticks at 0 (watchdog style)
//   COUNT_UP = 1 : counts up and sticks at MAX_VAL (hold/debounce style)
// Ports:
//   i_clk      in  1 : clock
//   i_reset    in  1 : synchronous active-high reset, count -> 0
//   i_load     in  1 : load i_load_val this cycle (wins over counting)
//   i_load_val in  W : value to load
//   o_count    out W : current count
module hold_timer #(
  parameter int unsigned MAX_VAL  = 1,
  parameter bit          COUNT_UP = 1'b0,
  parameter int unsigned W        = $clog2(MAX_VAL + 1)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] LIMIT = W'(MAX_VAL);
  localparam logic [W-1:0] ZERO  = {W{1'b0}};
  localparam logic [W-1:0] ONE   = W'(1'b1);

  logic [W-1:0] r_count;

  // Count register: load first, otherwise step toward the end that saturates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= ZERO;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (COUNT_UP) begin
      if (r_count != LIMIT) begin
        r_count <= r_count + ONE;
      end
    end else begin
      if (r_count != ZERO) begin
        r_count <= r_count - ONE;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/motor_cmd_arbiter.sv
// motor_cmd_arbiter: picks the single command that reaches the motor driver.
// Priority: proximity interlock (blocks FWD only) > IR manual override >
// autonomous robot_fsm command. Includes an IR command watchdog and,
// when MOTOR_ARB_DEADTIME_EN is defined, a forced STOP of DEADTIME_CYC
// cycles between two different non-STOP commands.
// Ports:
//   i_clk           in  1 : system clock
//   i_reset         in  1 : synchronous active-high reset
//   i_fsm_cmd       in  5 : autonomous command
//   i_overwrite     in  1 : manual (IR) mode selected
//   i_ir_cmd        in  5 : IR command, valid with i_ir_valid
//   i_ir_valid      in  1 : one-cycle IR strobe
//   i_proximity     in  1 : obstacle detected (already synchronised)
//   o_motor_cmd     out 5 : registered motor command
//   o_grant         out 2 : source of the request behind o_motor_cmd
//   o_safety_active out 1 : interlock engaged
//   o_deadtime_busy out 1 : in the reversal dead-time (0 without the macro)
// Build option: MOTOR_ARB_DEADTIME_EN enables the dead-time state/counter.
module motor_cmd_arbiter
  import robot_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC    = 2_500_000,
  parameter int unsigned IR_TIMEOUT_CYC  = 7_500_000,
  parameter int unsigned SAFETY_HOLD_CYC = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_fsm_cmd,
  input  logic       i_overwrite,
  input  logic [4:0] i_ir_cmd,
  input  logic       i_ir_valid,
  input  logic       i_proximity,
  output logic [4:0] o_motor_cmd,
  output logic [1:0] o_grant,
  output logic       o_safety_active,
  output logic       o_deadtime_busy
);

  localparam int unsigned IR_W   = $clog2(IR_TIMEOUT_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(SAFETY_HOLD_CYC + 1);

  localparam logic [IR_W-1:0]   IR_LOAD   = IR_W'(IR_TIMEOUT_CYC);
  localparam logic [IR_W-1:0]   IR_ZERO   = {IR_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(SAFETY_HOLD_CYC);

  logic [IR_W-1:0]   w_ir_timer;
  logic [HOLD_W-1:0] w_hold_cnt;
  motor_cmd_t        r_ir_q;
  logic              r_safety_active;
  logic              w_ir_expired;
  motor_cmd_t        w_raw;
  motor_cmd_t        w_req;
  grant_t            w_grant;
  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  motor_cmd_t        r_motor;
  motor_cmd_t        w_motor_nxt;
  grant_t            r_grant;

  // IR watchdog: reloaded by every strobe, a zero count means expired.
  hold_timer #(
    .MAX_VAL (IR_TIMEOUT_CYC),
    .COUNT_UP(1'b0),
    .W       (IR_W)
  ) u_ir_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (i_ir_valid),
    .i_load_val(IR_LOAD),
    .o_count   (w_ir_timer)
  );

  // Safety hold: counts consecutive proximity-low cycles.
  hold_timer #(
    .MAX_VAL (SAFETY_HOLD_CYC),
    .COUNT_UP(1'b1),
    .W       (HOLD_W)
  ) u_safety_hold (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (i_proximity),
    .i_load_val(HOLD_ZERO),
    .o_count   (w_hold_cnt)
  );

  // IR command latch, captured on the strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ir_q <= CMD_STOP;
    end else if (i_ir_valid) begin
      r_ir_q <= i_ir_cmd;
    end
  end

  // Interlock flag: set by proximity, released one cycle after the hold completes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_safety_active <= 1'b0;
    end else if (i_proximity) begin
      r_safety_active <= 1'b1;
    end else if (w_hold_cnt == HOLD_DONE) begin
      r_safety_active <= 1'b0;
    end
  end

  assign w_ir_expired = (w_ir_timer == IR_ZERO);

  // Raw request before legality and interlock filtering.
  always_comb begin
    w_raw = i_fsm_cmd;
    if (i_overwrite) begin
      if (w_ir_expired) begin
        w_raw = CMD_STOP;
      end else begin
        w_raw = r_ir_q;
      end
    end else begin
      w_raw = i_fsm_cmd;
    end
  end

  // Final request and grant: illegal codes become STOP, the interlock blocks FWD only.
  always_comb begin
    w_req   = CMD_STOP;
    w_grant = GRANT_FSM;
    if (cmd_is_valid(w_raw)) begin
      w_req = w_raw;
    end else begin
      w_req = CMD_STOP;
    end
    if (r_safety_active && (w_raw == CMD_FWD)) begin
      w_req   = CMD_STOP;
      w_grant = GRANT_SAFETY;
    end else if (i_overwrite) begin
      w_grant = GRANT_IR;
    end else begin
      w_grant = GRANT_FSM;
    end
  end

`ifdef MOTOR_ARB_DEADTIME_EN
  localparam int unsigned DT_W = $clog2(DEADTIME_CYC + 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYC - 1);
  localparam logic [DT_W-1:0] DT_ZERO = {DT_W{1'b0}};
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1'b1);

  logic [DT_W-1:0] r_dt_cnt;
  logic            w_dt_load;
  logic            r_deadtime_busy;
`endif

  // Next state and next motor command.
  always_comb begin
    w_state_nxt = r_state;
    w_motor_nxt = r_motor;
`ifdef MOTOR_ARB_DEADTIME_EN
    w_dt_load   = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_req != CMD_STOP) begin
          w_state_nxt = ARB_DRIVE;
          w_motor_nxt = w_req;
        end else begin
          w_state_nxt = ARB_IDLE;
          w_motor_nxt = CMD_STOP;
        end
      end
      ARB_DRIVE: begin
        if (w_req == r_motor) begin
          w_state_nxt = ARB_DRIVE;
        end else if (w_req == CMD_STOP) begin
          w_state_nxt = ARB_IDLE;
          w_motor_nxt = CMD_STOP;
        end else begin
`ifdef MOTOR_ARB_DEADTIME_EN
          w_state_nxt = ARB_DEADTIME;
          w_motor_nxt = CMD_STOP;
          w_dt_load   = 1'b1;
`else
          w_state_nxt = ARB_DRIVE;
          w_motor_nxt = w_req;
`endif
        end
      end
`ifdef MOTOR_ARB_DEADTIME_EN
      ARB_DEADTIME: begin
        // The exit uses whatever is requested now, not what caused the reversal.
        if (r_dt_cnt != DT_ZERO) begin
          w_state_nxt = ARB_DEADTIME;
          w_motor_nxt = CMD_STOP;
        end else if (w_req == CMD_STOP) begin
          w_state_nxt = ARB_IDLE;
          w_motor_nxt = CMD_STOP;
        end else begin
          w_state_nxt = ARB_DRIVE;
          w_motor_nxt = w_req;
        end
      end
`endif
      default: begin
        w_state_nxt = ARB_IDLE;
        w_motor_nxt = CMD_STOP;
      end
    endcase
  end

  // State, motor command and grant registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_motor <= CMD_STOP;
      r_grant <= GRANT_FSM;
    end else begin
      r_state <= w_state_nxt;
      r_motor <= w_motor_nxt;
      r_grant <= w_grant;
    end
  end

`ifdef MOTOR_ARB_DEADTIME_EN
  // Dead-time counter: loaded on a reversal, counts down while in DEADTIME, never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dt_cnt <= DT_ZERO;
    end else if (w_dt_load) begin
      r_dt_cnt <= DT_LOAD;
    end else if ((r_state == ARB_DEADTIME) && (r_dt_cnt != DT_ZERO)) begin
      r_dt_cnt <= r_dt_cnt - DT_ONE;
    end
  end

  // Busy flag registered alongside the state it reports.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_deadtime_busy <= 1'b0;
    end else begin
      r_deadtime_busy <= (w_state_nxt == ARB_DEADTIME);
    end
  end

  assign o_deadtime_busy = r_deadtime_busy;
`else
  assign o_deadtime_busy = 1'b0;
`endif

  assign o_motor_cmd     = r_motor;
  assign o_grant         = r_grant;
  assign o_safety_active = r_safety_active;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
module tb_motor_cmd_arbiter;

  localparam int DT      = 4;
  localparam int IR_TO   = 10;
  localparam int HOLD    = 3;
`ifdef MOTOR_ARB_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  localparam logic [4:0] STOP  = 5'b00000;
  localparam logic [4:0] FWD   = 5'b00001;
  localparam logic [4:0] REV   = 5'b00010;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] RIGHT = 5'b01000;
  localparam logic [4:0] SPIN  = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] fsm_cmd = 5'b00000;
  logic       overwrite = 1'b0;
  logic [4:0] ir_cmd = 5'b00000;
  logic       ir_valid = 1'b0;
  logic       proximity = 1'b0;
  logic [4:0] motor_cmd;
  logic [1:0] grant;
  logic       safety_active;
  logic       deadtime_busy;

  motor_cmd_arbiter #(
    .DEADTIME_CYC   (DT),
    .IR_TIMEOUT_CYC (IR_TO),
    .SAFETY_HOLD_CYC(HOLD)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_fsm_cmd      (fsm_cmd),
    .i_overwrite    (overwrite),
    .i_ir_cmd       (ir_cmd),
    .i_ir_valid     (ir_valid),
    .i_proximity    (proximity),
    .o_motor_cmd    (motor_cmd),
    .o_grant        (grant),
    .o_safety_active(safety_active),
    .o_deadtime_busy(deadtime_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] motor;
    logic [1:0] grant;
    logic       safety;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, described by event times rather than counters.
  int         m_cyc = 0;
  bit         m_ir_seen = 1'b0;
  int         m_ir_last = 0;
  logic [4:0] m_irq = 5'b00000;
  bit         m_prox_seen = 1'b0;
  int         m_prox_last = 0;
  logic [4:0] m_motor = 5'b00000;
  logic [1:0] m_grant = 2'd0;
  int         m_pending = 0;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [4:0] fsm, input logic ov,
                            input logic [4:0] ir, input logic irv, input logic prox);
    exp_t       e;
    logic [4:0] raw;
    logic [4:0] req;
    logic [1:0] g;
    bit         expired;
    bit         safety;
    if (rst) begin
      m_ir_seen   = 1'b0;
      m_prox_seen = 1'b0;
      m_irq       = STOP;
      m_motor     = STOP;
      m_grant     = 2'd0;
      m_pending   = 0;
    end else begin
      expired = !m_ir_seen || (((m_cyc - 1) - m_ir_last) >= IR_TO);
      safety  = m_prox_seen && (((m_cyc - 1) - m_prox_last) <= HOLD);
      raw = ov ? (expired ? STOP : m_irq) : fsm;
      req = (raw inside {STOP, FWD, REV, LEFT, RIGHT, SPIN}) ? raw : STOP;
      g   = ov ? 2'd1 : 2'd0;
      if (safety && raw == FWD) begin
        req = STOP;
        g   = 2'd2;
      end
      m_grant = g;
      if (m_pending > 1) begin
        m_pending--;
      end else if (m_pending == 1) begin
        m_pending = 0;
        m_motor   = req;
      end else if (m_motor == STOP || req == STOP || !DT_EN) begin
        m_motor = req;
      end else if (req != m_motor) begin
        m_motor   = STOP;
        m_pending = DT;
      end
      if (irv) begin
        m_irq     = ir;
        m_ir_last = m_cyc;
        m_ir_seen = 1'b1;
      end
      if (prox) begin
        m_prox_last = m_cyc;
        m_prox_seen = 1'b1;
      end
    end
    e.motor  = m_motor;
    e.grant  = m_grant;
    e.safety = m_prox_seen && ((m_cyc - m_prox_last) <= HOLD);
    e.busy   = (m_pending > 0);
    sb_q.push_back(e);
    m_cyc++;
  endtask

  task automatic step(input logic rst, input logic [4:0] fsm, input logic ov,
                      input logic [4:0] ir, input logic irv, input logic prox);
    @(negedge clk);
    reset     = rst;
    fsm_cmd   = fsm;
    overwrite = ov;
    ir_cmd    = ir;
    ir_valid  = irv;
    proximity = prox;
    model_edge(rst, fsm, ov, ir, irv, prox);
  endtask

  // Monitor: every cycle the DUT presents an output, compare it to the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("motor_cmd", motor_cmd, e.motor);
        chk("grant", {3'b000, grant}, {3'b000, e.grant});
        chk("safety_active", {4'b0000, safety_active}, {4'b0000, e.safety});
        chk("deadtime_busy", {4'b0000, deadtime_busy}, {4'b0000, e.busy});
      end
    end
  end

  initial begin
    logic [4:0] tab [8];
    logic [4:0] cur_fsm;
    logic       cur_ov;
    int         stop_seen;
    int         busy_seen;
    tab[0] = STOP; tab[1] = FWD; tab[2] = REV; tab[3] = LEFT;
    tab[4] = RIGHT; tab[5] = SPIN; tab[6] = FWD; tab[7] = 5'b00011;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, STOP, 1'b0, STOP, 1'b0, 1'b0);

    // FSM reversal FWD -> REV; count STOP and busy cycles directly.
    for (int i = 0; i < 3; i++) step(1'b0, FWD, 1'b0, STOP, 1'b0, 1'b0);
    stop_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, REV, 1'b0, STOP, 1'b0, 1'b0);
      if (motor_cmd == STOP) stop_seen++;
      if (deadtime_busy) busy_seen++;
    end
    chk("reversal_stop_cycles", 5'(stop_seen), DT_EN ? 5'd4 : 5'd0);
    chk("reversal_busy_cycles", 5'(busy_seen), DT_EN ? 5'd4 : 5'd0);
    chk("reversal_final", motor_cmd, REV);

    // IR override with LEFT, then watchdog expiry.
    step(1'b0, FWD, 1'b1, LEFT, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, FWD, 1'b1, STOP, 1'b0, 1'b0);

    // Safety pulse while driving FWD, then REV during an interlock.
    for (int i = 0; i < 4; i++) step(1'b0, FWD, 1'b0, STOP, 1'b0, 1'b0);
    step(1'b0, FWD, 1'b0, STOP, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, FWD, 1'b0, STOP, 1'b0, 1'b0);
    step(1'b0, FWD, 1'b0, STOP, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, REV, 1'b0, STOP, 1'b0, 1'b0);

    // Invalid encoding.
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00011, 1'b0, STOP, 1'b0, 1'b0);

    // Reset in the middle of a dead-time, with a live IR command latched.
    step(1'b0, FWD, 1'b0, LEFT, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, FWD, 1'b0, STOP, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, REV, 1'b0, STOP, 1'b0, 1'b0);
    step(1'b1, REV, 1'b0, STOP, 1'b0, 1'b0);
    step(1'b0, REV, 1'b1, STOP, 1'b0, 1'b0);
    chk("reset_mid_motion", motor_cmd, STOP);
    step(1'b0, REV, 1'b1, STOP, 1'b0, 1'b0);
    chk("reset_clears_ir", motor_cmd, STOP);

    // Randomised traffic.
    cur_fsm = FWD;
    cur_ov  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic       r_rst;
      logic       r_irv;
      logic       r_prox;
      logic [4:0] r_ir;
      if ($urandom_range(7, 0) == 0) cur_fsm = tab[$urandom_range(7, 0)];
      if ($urandom_range(19, 0) == 0) cur_ov = ~cur_ov;
      r_irv  = ($urandom_range(9, 0) == 0);
      r_ir   = ($urandom_range(15, 0) == 0) ? 5'($urandom) : tab[$urandom_range(5, 0)];
      r_prox = ($urandom_range(24, 0) == 0);
      r_rst  = ($urandom_range(299, 0) == 0);
      step(r_rst, cur_fsm, cur_ov, r_ir, r_irv, r_prox);
    end

    step(1'b0, STOP, 1'b0, STOP, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 5'(sb_q.size()), 5'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_cmd_arbiter.md
# motor_cmd_arbiter

Sits between the command sources and the `motor` driver and produces the single `motor_cmd` that reaches the wheels. Sources, highest priority first:
- Proximity safety interlock.
- IR manual override (`overwrite` plus IR command).
- Autonomous `robot_fsm` command.

The block also enforces an IR command watchdog and, when configured, a stop dead-time between direction reversals.

## Interface
- `DEADTIME_CYC`, 2_500_000: STOP cycles inserted between two different non-STOP commands (50 ms at 50 MHz); legal range ≥1.
- `IR_TIMEOUT_CYC`, 7_500_000: cycles a latched IR command stays valid after the last `ir_valid`; legal range ≥1.
- `SAFETY_HOLD_CYC`, 1_000_000: consecutive cycles `proximity` must be low before the interlock releases; legal range ≥1.
- `clk` in 1: system clock, `CLOCK_50`.
- `reset` in 1: synchronous, active-high.
- `fsm_cmd` in 5: autonomous command from `robot_fsm`.
- `overwrite` in 1: manual mode selected by IR.
- `ir_cmd` in 5: manual command decoded from the remote.
- `ir_valid` in 1: one-cycle strobe; `ir_cmd` is valid in that cycle.
- `proximity` in 1: obstacle detected, already synchronised.
- `motor_cmd` out 5: registered command to `motor`.
- `grant` out 2: source of the current request. 0 = FSM, 1 = IR, 2 = SAFETY, 3 = unused.
- `safety_active` out 1: interlock engaged.
- `deadtime_busy` out 1: high while in DEADTIME.

## Operation
- Command encoding:
  - STOP = 5'b00000.
  - FWD = 5'b00001.
  - REV = 5'b00010.
  - LEFT = 5'b00100.
  - RIGHT = 5'b01000.
  - SPIN = 5'b10000.
  - Any other value is treated as STOP.
- IR latch: when `ir_valid` is high, `ir_q <= ir_cmd` and `ir_timer <= IR_TIMEOUT_CYC`. Otherwise `ir_timer` decrements and saturates at 0. `ir_timer == 0` means the IR command has expired.
- Interlock:
  - `proximity` high sets `safety_active` and clears the hold counter.
  - While `proximity` is low, the hold counter increments.
  - `safety_active` clears in the cycle after the counter reaches `SAFETY_HOLD_CYC`.
- Request, combinational, evaluated in this order:
  - raw = `overwrite` ? (expired ? STOP : `ir_q`) : `fsm_cmd`.
  - If raw is an invalid encoding, req = STOP.
  - If `safety_active` and raw == FWD, req = STOP and `grant` = 2. Only FWD is blocked; REV and turns pass through.
  - Otherwise `grant` = `overwrite` ? 1 : 0.
- State machine, with `motor_cmd` registered in every state:
  - IDLE: `motor_cmd` = STOP. If req ≠ STOP, go to DRIVE and set `motor_cmd <= req`.
  - DRIVE:
    - req == `motor_cmd`: stay.
    - req == STOP: go to IDLE and set `motor_cmd <= STOP`.
    - Any other non-STOP req: go to DEADTIME, set `motor_cmd <= STOP`, and load `dt_cnt <= DEADTIME_CYC-1`.
  - DEADTIME:
    - `motor_cmd` holds STOP; `dt_cnt` decrements.
    - At `dt_cnt == 0`: if req == STOP go to IDLE; otherwise go to DRIVE with `motor_cmd <= req`, using the request at that cycle, not the one that triggered DEADTIME.
    - Request changes during DEADTIME never shorten it.
- Simultaneous events: in the same cycle, `ir_valid` updates `ir_q` and `proximity` sets `safety_active`. Both take effect on the request one cycle later.

## Timing
- Reset values: `motor_cmd` = STOP, state = IDLE, `ir_timer` = 0 (IR expired), `safety_active` = 0, hold counter = 0, `dt_cnt` = 0, `grant` = 0, `deadtime_busy` = 0.
- Reset asserted mid-DRIVE or mid-DEADTIME forces STOP and IDLE at the next edge.
- Latency from `fsm_cmd` or `overwrite` to `motor_cmd` is 1 cycle.
- Latency from `ir_valid` to `motor_cmd` is 2 cycles (latch, then register).
- Latency from `proximity` rising to FWD→STOP on `motor_cmd` is 2 cycles.
- A reversal holds STOP for exactly `DEADTIME_CYC` cycles.
- Counters are sized with `$clog2(param+1)` and never wrap.

## Configuration
- `MOTOR_ARB_DEADTIME_EN` defined: DEADTIME state and `dt_cnt` are present, behaving as above.
- `MOTOR_ARB_DEADTIME_EN` undefined:
  - DRIVE loads any differing non-STOP req directly, with 1-cycle latency.
  - The DEADTIME state and counter are not built.
  - `deadtime_busy` is tied to 0.
  - `DEADTIME_CYC` is ignored.

## Structure
- Shared package `robot_pkg` holds:
  - `motor_cmd_t` and the CMD_* constants (STOP, FWD, REV, LEFT, RIGHT, SPIN).
  - `grant_t` (GRANT_FSM, GRANT_IR, GRANT_SAFETY).
  - The arbiter state enum.
- One sub-module, `hold_timer`: a parameterised load/decrement-or-increment saturating counter, instantiated for the IR watchdog and the safety hold.
- The dead-time counter stays inline so it can be compiled out.

## Test plan
Bench parameters: `DEADTIME_CYC`=4, `IR_TIMEOUT_CYC`=10, `SAFETY_HOLD_CYC`=3.
- FSM reversal, macro defined: `fsm_cmd` FWD then REV → FWD, STOP ×4 with `deadtime_busy`=1, then REV.
- IR override: `overwrite`=1 and `ir_valid` with LEFT, `fsm_cmd`=FWD → LEFT 2 cycles later with `grant`=1. With no further strobe, STOP follows after the 10-cycle timeout.
- Safety: FWD driving, `proximity` pulsed 1 cycle → STOP with `grant`=2. FWD resumes only after 3 low cycles plus one cycle. REV requested during the interlock passes through.
- Invalid encoding: `fsm_cmd`=5'b00011 → STOP, state IDLE.
- Reset during DEADTIME (`dt_cnt`=2) → next cycle `motor_cmd`=STOP, IDLE, `ir_timer`=0.
- Macro undefined: FWD→REV → REV on the next cycle, with no STOP inserted.
